// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle word memory on the core's load/store port; build with MISALIGN_TRAP_EN to trap misaligned accesses.
// Latency: Mem_Ready pulses LATENCY+1 cycles after the accepting edge; one access per LATENCY+2 cycles.
// Backpressure: one access in flight; the requester holds its request until Mem_Ready, Busy marks the access in progress.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_Read,
  input  logic        Mem_Write,
  input  logic [31:0] Addr,
  input  logic [31:0] Write_Data,
  output logic [31:0] Read_Data,
  output logic        Mem_Ready,
  output logic        Busy,
  output logic        Mem_Err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              accept;
  logic              commit;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic              wr_q;
  logic              mis_q;
  logic [31:0]       mem [DEPTH];

  // Only the word index (and, with trapping, the byte offset) of Addr matters.
  logic unused_addr;
  assign unused_addr = ^{Addr[31:ADDR_W+2], Addr[1:0]};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    Busy      = 1'b0;
    Mem_Ready = 1'b0;
    Mem_Err   = 1'b0;
    Read_Data = '0;
    case (state)
      IDLE: begin
        if (Mem_Read | Mem_Write) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = (LATENCY > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        Busy = 1'b1;
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP: begin
        Busy      = 1'b1;
        Mem_Ready = 1'b1;
        Mem_Err   = mis_q;
        state_nxt = IDLE;
        // A store lands on the edge leaving RESP, so a reset here drops it.
        if (wr_q)        commit    = ~mis_q;
        else if (!mis_q) Read_Data = mem[idx_q];
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else if (accept) begin
      idx_q   <= Addr[ADDR_W+1:2];
      wdata_q <= Write_Data;
      wr_q    <= Mem_Write;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)       mis_q <= 1'b0;
    else if (accept) mis_q <= |Addr[1:0];
  end
`else
  assign mis_q = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (commit) mem[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY=2 and LATENCY=0) checked against an array-based memory model.
`timescale 1ns/1ps
module tb_data_mem_responder;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        rst   [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdat  [2];
  logic [31:0] rdata [2];
  logic        rdy   [2];
  logic        busy  [2];
  logic        err   [2];

  data_mem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(2)) dut_l2 (
    .Clk(Clk), .Reset(rst[0]), .Mem_Read(rd[0]), .Mem_Write(wr[0]), .Addr(addr[0]),
    .Write_Data(wdat[0]), .Read_Data(rdata[0]), .Mem_Ready(rdy[0]), .Busy(busy[0]), .Mem_Err(err[0]));

  data_mem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(0)) dut_l0 (
    .Clk(Clk), .Reset(rst[1]), .Mem_Read(rd[1]), .Mem_Write(wr[1]), .Addr(addr[1]),
    .Write_Data(wdat[1]), .Read_Data(rdata[1]), .Mem_Ready(rdy[1]), .Busy(busy[1]), .Mem_Err(err[1]));

  int checks = 0;
  int errors = 0;
  int lat [2];

  // Reference memory: word contents plus a flag for words written since time zero.
  logic [31:0] model [2][256];
  bit          known [2][256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access from an IDLE cycle; returns load data and the accept time in cycles.
  task automatic access(input int d, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input bit wiggle,
                        output logic [31:0] rd_o, output int acc_cyc);
    int   n = 0;
    int   nbusy = 0;
    bit   done = 0;
    logic e_o = 1'b0;
    int   idx = int'(a[9:2]);
    bit   mis = 0;
    rd_o = 'x;
`ifdef MISALIGN_TRAP_EN
    mis = (a[1:0] != 2'b00);
`endif
    @(negedge Clk);
    check("idle_busy", busy[d], 0);
    rd[d] = r; wr[d] = w; addr[d] = a; wdat[d] = wd;
    @(posedge Clk);
    acc_cyc = int'($time / 10);
    while (!done && n < 40) begin
      @(negedge Clk);
      n++;
      if (busy[d]) nbusy++;
      if (rdy[d]) begin
        done = 1;
        rd_o = rdata[d];
        e_o  = err[d];
      end else begin
        check("rdata_outside_resp", rdata[d], 0);
        check("err_outside_resp", err[d], 0);
        if (wiggle) begin
          rd[d] = 1'($urandom); wr[d] = 1'($urandom);
          addr[d] = $urandom; wdat[d] = $urandom;
        end
      end
    end
    rd[d] = 0; wr[d] = 0;
    check("ready_seen", rdy[d], 1);
    check("latency", n, lat[d] + 1);
    check("busy_cycles", nbusy, lat[d] + 1);
    check("mem_err", e_o, mis);
    if (w || mis) check("rdata_no_load", rd_o, 0);
    else if (known[d][idx]) check("rdata_model", rd_o, model[d][idx]);
    if (w && !mis) begin
      model[d][idx] = wd;
      known[d][idx] = 1;
    end
  endtask

  initial begin
    logic [31:0] r;
    int t0, t1, t2;
    lat[0] = 2; lat[1] = 0;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1; rd[i] = 0; wr[i] = 0; addr[i] = 0; wdat[i] = 0;
      for (int j = 0; j < 256; j++) known[i][j] = 0;
    end
    #12;
    for (int i = 0; i < 2; i++) begin
      check("rst_rdata", rdata[i], 0);
      check("rst_ready", rdy[i], 0);
      check("rst_busy", busy[i], 0);
      check("rst_err", err[i], 0);
    end
    @(negedge Clk);
    rst[0] = 0; rst[1] = 0;

    // LATENCY=2 store then load of the same word.
    access(0, 0, 1, 32'h40, 32'hCAFEF00D, 0, r, t0);
    access(0, 1, 0, 32'h40, 32'h0, 0, r, t1);
    check("l2_read_40", r, 32'hCAFEF00D);
    check("l2_spacing", t1 - t0, 4);

    // LATENCY=0 back-to-back loads.
    access(1, 0, 1, 32'h04, 32'h11111111, 0, r, t0);
    access(1, 0, 1, 32'h08, 32'h22222222, 0, r, t0);
    access(1, 1, 0, 32'h04, 32'h0, 0, r, t1);
    check("l0_read_04", r, 32'h11111111);
    access(1, 1, 0, 32'h08, 32'h0, 0, r, t2);
    check("l0_read_08", r, 32'h22222222);
    check("l0_spacing", t2 - t1, 2);

    // Write wins over a simultaneous read.
    access(0, 1, 1, 32'h20, 32'h5A5A5A5A, 0, r, t0);
    access(0, 1, 0, 32'h20, 32'h0, 0, r, t0);
    check("both_req_write", r, 32'h5A5A5A5A);

    // Index wraps modulo DEPTH.
    access(0, 0, 1, 32'h400, 32'h12345678, 0, r, t0);
    access(0, 1, 0, 32'h000, 32'h0, 0, r, t0);
    check("addr_wrap", r, 32'h12345678);

    // Misaligned store to the word holding 0xCAFEF00D.
    access(0, 0, 1, 32'h43, 32'hFFFFFFFF, 0, r, t0);
    access(0, 1, 0, 32'h40, 32'h0, 0, r, t0);
`ifdef MISALIGN_TRAP_EN
    check("misalign_read_40", r, 32'hCAFEF00D);
`else
    check("misalign_read_40", r, 32'hFFFFFFFF);
`endif

    // Reset in the middle of a store's wait states.
    access(0, 0, 1, 32'h10, 32'h01010101, 0, r, t0);
    @(negedge Clk);
    wr[0] = 1; addr[0] = 32'h10; wdat[0] = 32'hDEADBEEF;
    @(posedge Clk);
    @(negedge Clk);
    check("pre_rst_busy", busy[0], 1);
    #2 rst[0] = 1;
    #1;
    check("midrst_busy", busy[0], 0);
    check("midrst_ready", rdy[0], 0);
    check("midrst_rdata", rdata[0], 0);
    check("midrst_err", err[0], 0);
    wr[0] = 0;
    @(negedge Clk);
    rst[0] = 0;
    access(0, 1, 0, 32'h10, 32'h0, 0, r, t0);
    check("rst_abort_read", r, 32'h01010101);

    // Random traffic over a small set of words with aliasing and mid-transfer input churn.
    for (int k = 0; k < 160; k++) begin
      int d = $urandom_range(0, 1);
      logic rq = 1'($urandom);
      logic wq = 1'($urandom);
      logic [31:0] a = {$urandom_range(0, 7) * 32'h400} | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if (!rq && !wq) rq = 1;
      access(d, rq, wq, a, $urandom, 1'($urandom), r, t0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
